ikaopll_pg_multi: RTL and testbench
===================================

IKAOPLL_PG_MULTI -- requirements
Module: IKAOPLL_pg_multi

Interface
REQ-001 Parameter CH_CNT, default 18: operator slots time-multiplexed through the accumulator ring; legal range 4..64.
REQ-002 Parameter FNUM_W, default 9: F-number width; legal values 9 or 10.
REQ-003 Parameter PHASE_W, default 19: accumulator width per slot; legal range 16..24.
REQ-004 Parameter OUT_W, default 10: output phase width; legal when OUT_W <= PHASE_W.
REQ-005 Parameter USE_PIPELINED_MULTIPLIER, default 1: 1 = multiply in its own stage, 0 = combinational multiply; latency identical in both modes.
REQ-006 i_EMUCLK  in  1  emulator master clock; the block's only clock.
REQ-007 i_IC_n  in  1  reset, synchronous, active-low.
REQ-008 i_phi1_NCEN_n  in  1  active-low clock enable; one slot step per enabled edge.
REQ-009 i_SYNC  in  1  slot-counter resync; sampled on enabled edges.
REQ-010 i_FNUM  in  FNUM_W  F-number of the current input slot.
REQ-011 i_BLOCK  in  3  octave of the current input slot.
REQ-012 i_MUL  in  4  multiple index of the current input slot.
REQ-013 i_PM  in  1  phase-modulation enable of the current input slot.
REQ-014 i_PMVAL  in  3  global PM value: bit 2 = sign, bits 1:0 = depth.
REQ-015 i_PHASE_RST  in  1  key-on phase reset of the current input slot.
REQ-016 i_HOLD  in  1  test freeze: stored phases are not advanced.
REQ-017 o_SLOT  out  6  slot index tagged to o_OP_PHASE.
REQ-018 o_OP_PHASE  out  OUT_W  phase bits [PHASE_W-1 : PHASE_W-OUT_W] of the updated slot phase.
REQ-019 o_NOISE  out  1  LFSR noise bit.

Function
REQ-020 All state shall change only on i_EMUCLK rising edges with i_phi1_NCEN_n low, except reset.
REQ-021 The input slot counter shall increment per enabled edge, wrap CH_CNT-1 -> 0, and load 1 on an enabled edge where i_SYNC=1, so the slot presented alongside i_SYNC is slot 0.
REQ-022 PM term: depth 0 -> 0; depth 1 or 3 -> FNUM[FNUM_W-1:FNUM_W-2]; depth 2 -> FNUM[FNUM_W-1:FNUM_W-3]; the term is 0 when i_PM=0.
REQ-023 fm = 2*FNUM + term when sign=0, else 2*FNUM - term; a negative fm shall clamp to 0; width FNUM_W+2.
REQ-024 delta = (fm << BLOCK) >> 1, computed without truncation.
REQ-025 MUL shall apply x2 factors {1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30} for index 0..15, then >>1; the product shall be truncated to PHASE_W bits.
REQ-026 new_phase = (i_PHASE_RST ? 0 : stored_phase) + (i_HOLD ? 0 : delta), modulo 2^PHASE_W; the result shall be written back for that slot.
REQ-027 When i_PHASE_RST=1 and i_HOLD=1 together, new_phase shall be 0.
REQ-028 Latency: inputs of slot s presented on enabled edge N shall produce o_OP_PHASE and o_SLOT=s after edge N+3; outputs shall be registered.
REQ-029 The stored-phase ring shall be a CH_CNT-deep delay, so each slot's previous phase returns exactly when that slot's inputs are presented again.
REQ-030 LFSR: 23 bits, shifted per enabled edge; bit0_in = (b22 XOR b8) OR (register==0); o_NOISE = b22.
REQ-031 Changing i_SYNC mid-revolution shall only realign slot numbering; ring contents shall not be cleared.

Reset
REQ-032 While i_IC_n=0 at a clock edge, regardless of enable, the slot counter, all stored phases, all pipeline registers and the LFSR shall clear to 0.
REQ-033 During and after reset, until the first output update, o_OP_PHASE=0, o_SLOT=0, o_NOISE=0.
REQ-034 The first enabled edge after reset shall load 1 into the LFSR, via the zero-escape term.

Verification
REQ-035 Defaults; every slot FNUM=0x100, BLOCK=4, MUL=1, PM=0 -> delta=4096; on revolution k each slot's o_OP_PHASE=8k, wrapping to 0 at k=128.
REQ-036 Slot 5 PHASE_RST pulsed for one revolution after 10 revolutions -> slot 5 output goes to 8, then continues 16, 24, ...; other slots are unaffected.
REQ-037 FNUM=0x1C0, PM=1, PMVAL=3'b110 (sign=1, depth 2), BLOCK=1, MUL=0 -> fm=889, delta=889, product=444 per revolution.
REQ-038 MUL=15, FNUM=0x1FF, BLOCK=7 -> delta=65408, product=981120, stored mod 2^19 = 456832; accumulation wraps correctly.
REQ-039 i_HOLD=1 for 3 revolutions -> outputs repeat the same value per slot; i_SYNC at a non-zero counter value -> o_SLOT restarts at 0 three edges later.
REQ-040 Reset asserted mid-revolution -> all outputs are 0 and accumulation restarts from 0; after reset, the LFSR sequence reads 1, then follows the taps.

Source files
------------

// File: rtl/ikaopll_pg_multi.sv
// Time-multiplexed operator phase generator: per-slot F-number/block/multiple
// increment accumulated through a CH_CNT-deep phase ring, plus a 23-bit noise LFSR.
module ikaopll_pg_multi #(
  parameter int CH_CNT                   = 18,
  parameter int FNUM_W                   = 9,
  parameter int PHASE_W                  = 19,
  parameter int OUT_W                    = 10,
  parameter int USE_PIPELINED_MULTIPLIER = 1
) (
  input  logic              i_EMUCLK,
  input  logic              i_IC_n,
  input  logic              i_phi1_NCEN_n,
  input  logic              i_SYNC,
  input  logic [FNUM_W-1:0] i_FNUM,
  input  logic [2:0]        i_BLOCK,
  input  logic [3:0]        i_MUL,
  input  logic              i_PM,
  input  logic [2:0]        i_PMVAL,
  input  logic              i_PHASE_RST,
  input  logic              i_HOLD,
  output logic [5:0]        o_SLOT,
  output logic [OUT_W-1:0]  o_OP_PHASE,
  output logic              o_NOISE
);

  localparam int FM_W    = FNUM_W + 2;
  localparam int DELTA_W = FNUM_W + 8;
  localparam int MUL_W   = DELTA_W + 5;

  function automatic logic [4:0] mul_factor(input logic [3:0] m);
    logic [4:0] f;
    case (m)
      4'd0:  f = 5'd1;
      4'd1:  f = 5'd2;
      4'd2:  f = 5'd4;
      4'd3:  f = 5'd6;
      4'd4:  f = 5'd8;
      4'd5:  f = 5'd10;
      4'd6:  f = 5'd12;
      4'd7:  f = 5'd14;
      4'd8:  f = 5'd16;
      4'd9:  f = 5'd18;
      4'd10: f = 5'd20;
      4'd11: f = 5'd20;
      4'd12: f = 5'd24;
      4'd13: f = 5'd24;
      default: f = 5'd30;
    endcase
    return f;
  endfunction

  function automatic logic [PHASE_W-1:0] scale(input logic [DELTA_W-1:0] d,
                                               input logic [4:0] f);
    logic [MUL_W-1:0] p;
    p = MUL_W'(d) * MUL_W'(f);
    return PHASE_W'(p >> 1);
  endfunction

  logic en;
  assign en = ~i_phi1_NCEN_n;

  // Slot counter: the slot presented alongside i_SYNC is slot 0.
  logic [5:0] slot_cnt;
  logic [5:0] in_slot;
  assign in_slot = i_SYNC ? 6'd0 : slot_cnt;

  always_ff @(posedge i_EMUCLK) begin
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (!i_IC_n)
      slot_cnt <= '0;
    else if (en) begin
      if (i_SYNC)
        slot_cnt <= 6'd1;
      else if (slot_cnt == 6'(CH_CNT - 1))
        slot_cnt <= '0;
      else
        slot_cnt <= slot_cnt + 6'd1;
    end
  end

  logic [2:0]      pm_term;
  logic [FM_W:0]   fm_sum;
  logic [FM_W-1:0] fm;

  always_comb begin
    pm_term = '0;
    if (i_PM) begin
      case (i_PMVAL[1:0])
        2'd1, 2'd3: pm_term = {1'b0, i_FNUM[FNUM_W-1 -: 2]};
        2'd2:       pm_term = i_FNUM[FNUM_W-1 -: 3];
        default:    pm_term = '0;
      endcase
    end
  end

  // One guard bit above fm flags a negative difference, which clamps to 0.
  always_comb begin
    if (i_PMVAL[2])
      fm_sum = {2'b00, i_FNUM, 1'b0} - {{FNUM_W{1'b0}}, pm_term};
    else
      fm_sum = {2'b00, i_FNUM, 1'b0} + {{FNUM_W{1'b0}}, pm_term};
    fm = fm_sum[FM_W] ? '0 : fm_sum[FM_W-1:0];
  end

  logic [5:0]      s1_slot;
  logic [FM_W-1:0] s1_fm;
  logic [2:0]      s1_block;
  logic [3:0]      s1_mul;
  logic            s1_rst;
  logic            s1_hold;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      s1_slot  <= '0;
      s1_fm    <= '0;
      s1_block <= '0;
      s1_mul   <= '0;
      s1_rst   <= 1'b0;
      s1_hold  <= 1'b0;
    end else if (en) begin
      s1_slot  <= in_slot;
      s1_fm    <= fm;
      s1_block <= i_BLOCK;
      s1_mul   <= i_MUL;
      s1_rst   <= i_PHASE_RST;
      s1_hold  <= i_HOLD;
    end
  end

  logic [DELTA_W-1:0] s1_delta;
  logic [4:0]         s1_factor;
  assign s1_delta  = DELTA_W'(((DELTA_W + 1)'(s1_fm) << s1_block) >> 1);
  assign s1_factor = mul_factor(s1_mul);

  logic [5:0]         s2_slot;
  logic               s2_rst;
  logic               s2_hold;
  logic [PHASE_W-1:0] s3_prod_d;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      s2_slot <= '0;
      s2_rst  <= 1'b0;
      s2_hold <= 1'b0;
    end else if (en) begin
      s2_slot <= s1_slot;
      s2_rst  <= s1_rst;
      s2_hold <= s1_hold;
    end
  end

  // Both variants keep one register between stage 1 and stage 3; only the
  // placement of the multiplier relative to it differs.
  generate
    if (USE_PIPELINED_MULTIPLIER != 0) begin : g_mul_pipe
      logic [DELTA_W-1:0] delta_q;
      logic [4:0]         factor_q;
      always_ff @(posedge i_EMUCLK) begin
        if (!i_IC_n) begin
          delta_q  <= '0;
          factor_q <= '0;
        end else if (en) begin
          delta_q  <= s1_delta;
          factor_q <= s1_factor;
        end
      end
      assign s3_prod_d = scale(delta_q, factor_q);
    end else begin : g_mul_comb
      logic [PHASE_W-1:0] prod_q;
      always_ff @(posedge i_EMUCLK) begin
        if (!i_IC_n)
          prod_q <= '0;
        else if (en)
          prod_q <= scale(s1_delta, s1_factor);
      end
      assign s3_prod_d = prod_q;
    end
  endgenerate

  logic [5:0]         s3_slot;
  logic [PHASE_W-1:0] s3_prod;
  logic               s3_rst;
  logic               s3_hold;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      s3_slot <= '0;
      s3_prod <= '0;
      s3_rst  <= 1'b0;
      s3_hold <= 1'b0;
    end else if (en) begin
      s3_slot <= s2_slot;
      s3_prod <= s3_prod_d;
      s3_rst  <= s2_rst;
      s3_hold <= s2_hold;
    end
  end

  logic [PHASE_W-1:0] ring [CH_CNT];
  logic [PHASE_W-1:0] new_phase;

  assign new_phase = (s3_rst  ? '0 : ring[CH_CNT-1])
                   + (s3_hold ? '0 : s3_prod);

  always_ff @(posedge i_EMUCLK) begin
    // NOTE: the ring is a plain register shift chain, not a RAM, so every
    // entry can be cleared on reset.
    if (!i_IC_n) begin
      for (int i = 0; i < CH_CNT; i++) ring[i] <= '0;
    end else if (en) begin
      ring[0] <= new_phase;
      for (int i = 1; i < CH_CNT; i++) ring[i] <= ring[i-1];
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      o_SLOT     <= '0;
      o_OP_PHASE <= '0;
    end else if (en) begin
      o_SLOT     <= s3_slot;
      o_OP_PHASE <= new_phase[PHASE_W-1 -: OUT_W];
    end
  end

  // The all-zero term lets the register escape its lock-up state.
  logic [22:0] lfsr;
  logic        lfsr_in;
  assign lfsr_in = (lfsr[22] ^ lfsr[8]) | (lfsr == '0);

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n)
      lfsr <= '0;
    else if (en)
      lfsr <= {lfsr[21:0], lfsr_in};
  end

  assign o_NOISE = lfsr[22];

endmodule

// File: tb/tb_ikaopll_pg_multi.sv
// Bench for ikaopll_pg_multi: a per-step reference model pushes expected
// slot/phase pairs to a queue that is popped when the DUT output is due.
module tb_ikaopll_pg_multi;

  localparam int CH_CNT  = 18;
  localparam int FNUM_W  = 9;
  localparam int PHASE_W = 19;
  localparam int OUT_W   = 10;
  localparam int FACT [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  typedef struct {
    int unsigned      edge_no;
    logic [5:0]       slot;
    logic [OUT_W-1:0] phase;
  } exp_t;

  logic              clk = 1'b0;
  logic              ic_n;
  logic              ncen_n;
  logic              sync;
  logic [FNUM_W-1:0] fnum;
  logic [2:0]        block;
  logic [3:0]        mul;
  logic              pm;
  logic [2:0]        pmval;
  logic              phase_rst;
  logic              hold;
  logic [5:0]        slot;
  logic [OUT_W-1:0]  op_phase;
  logic              noise;

  ikaopll_pg_multi #(
    .CH_CNT(CH_CNT), .FNUM_W(FNUM_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W),
    .USE_PIPELINED_MULTIPLIER(1)
  ) dut (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen_n), .i_SYNC(sync),
    .i_FNUM(fnum), .i_BLOCK(block), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval),
    .i_PHASE_RST(phase_rst), .i_HOLD(hold),
    .o_SLOT(slot), .o_OP_PHASE(op_phase), .o_NOISE(noise)
  );

  always #5 clk = ~clk;

  int unsigned        m_edges;
  logic [5:0]         m_cnt;
  logic [PHASE_W-1:0] m_hist [CH_CNT];
  logic [22:0]        m_lfsr;
  exp_t               sb[$];
  int                 n_pass;
  int                 n_total;

  function automatic int ref_product(input int f, input int b, input int m,
                                     input bit p, input bit [2:0] pv);
    int term, fmv, delta;
    term = 0;
    if (p) begin
      if (pv[1:0] == 2'd1 || pv[1:0] == 2'd3) term = f >> (FNUM_W - 2);
      else if (pv[1:0] == 2'd2)               term = f >> (FNUM_W - 3);
    end
    fmv = pv[2] ? 2 * f - term : 2 * f + term;
    if (fmv < 0) fmv = 0;
    delta = (fmv << b) >> 1;
    return ((delta * FACT[m]) >> 1) % (1 << PHASE_W);
  endfunction

  task automatic apply_reset();
    ic_n = 1'b0; ncen_n = 1'b1; sync = 1'b0; fnum = '0; block = '0; mul = '0;
    pm = 1'b0; pmval = '0; phase_rst = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_edges = 0; m_cnt = '0; m_lfsr = '0; sb.delete();
    for (int i = 0; i < CH_CNT; i++) m_hist[i] = '0;
  endtask

  task automatic step(input int f, input int b, input int m, input bit p,
                      input bit [2:0] pv, input bit prst, input bit hld,
                      input bit syn, output bit due, output exp_t e, output bit ne);
    int pos, prod;
    logic [5:0] s;
    logic [PHASE_W-1:0] np;
    exp_t item;
    ic_n = 1'b1; ncen_n = 1'b0; sync = syn;
    fnum = FNUM_W'(f); block = 3'(b); mul = 4'(m); pm = p; pmval = pv;
    phase_rst = prst; hold = hld;
    s = syn ? 6'd0 : m_cnt;
    m_cnt = syn ? 6'd1 : ((m_cnt == 6'(CH_CNT - 1)) ? 6'd0 : m_cnt + 6'd1);
    m_edges++;
    pos = int'(m_edges % CH_CNT);
    prod = ref_product(f, b, m, p, pv);
    np = PHASE_W'((prst ? 0 : int'(m_hist[pos])) + (hld ? 0 : prod));
    m_hist[pos] = np;
    item.edge_no = m_edges; item.slot = s; item.phase = np[PHASE_W-1 -: OUT_W];
    sb.push_back(item);
    m_lfsr = {m_lfsr[21:0], (m_lfsr[22] ^ m_lfsr[8]) | (m_lfsr == 23'd0)};
    @(posedge clk);
    #1;
    ne = m_lfsr[22];
    due = 1'b0;
    e = item;
    if (sb.size() > 0 && sb[0].edge_no + 3 == m_edges) begin
      due = 1'b1;
      e = sb.pop_front();
    end
  endtask

  task automatic step_def(input bit prst, input bit hld, input bit syn,
                          output bit due, output exp_t e, output bit ne);
    step(256, 4, 1, 1'b0, 3'b000, prst, hld, syn, due, e, ne);
  endtask

  task automatic test_reset();
    bit due, ne;
    exp_t e;
    apply_reset();
    n_total++;
    if (op_phase !== '0 || slot !== '0 || noise !== 1'b0)
      $display("FAIL reset_state: phase=%0d slot=%0d noise=%0b expected 0/0/0", op_phase, slot, noise);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step_def(1'b0, 1'b0, 1'b0, due, e, ne);
      n_total++;
      if (op_phase !== '0 || slot !== '0 || noise !== 1'b0 || due)
        $display("FAIL reset_bubble[%0d]: phase=%0d slot=%0d noise=%0b expected 0/0/0", k, op_phase, slot, noise);
      else n_pass++;
    end
  endtask

  task automatic test_accumulate();
    bit due, ne;
    exp_t e;
    int rev;
    apply_reset();
    for (int r = 0; r < 130; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          rev = int'((e.edge_no - 1) / CH_CNT);
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne ||
              op_phase !== OUT_W'((8 * (rev + 1)) % 1024))
            $display("FAIL accumulate: slot=%0d phase=%0d noise=%0b expected %0d/%0d/%0b (rev %0d)",
                     slot, op_phase, noise, e.slot, e.phase, ne, rev);
          else n_pass++;
        end
      end
  endtask

  task automatic test_phase_rst();
    bit due, ne;
    exp_t e;
    int rev, cf;
    apply_reset();
    for (int r = 0; r < 15; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(r == 10 && s == 5, 1'b0, s == 0, due, e, ne);
        if (due) begin
          rev = int'((e.edge_no - 1) / CH_CNT);
          cf = (e.slot == 6'd5 && rev >= 10) ? 8 * (rev - 9) : 8 * (rev + 1);
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne || op_phase !== OUT_W'(cf))
            $display("FAIL phase_rst: slot=%0d phase=%0d expected %0d/%0d (closed form %0d)",
                     slot, op_phase, e.slot, e.phase, cf);
          else n_pass++;
        end
      end
  endtask

  task automatic test_pm();
    bit due, ne;
    exp_t e;
    int rev, cf;
    apply_reset();
    for (int r = 0; r < 6; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step(9'h1C0, 1, 0, 1'b1, 3'b110, 1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          rev = int'((e.edge_no - 1) / CH_CNT);
          cf = (444 * (rev + 1)) >> 9;
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne || op_phase !== OUT_W'(cf))
            $display("FAIL pm: slot=%0d phase=%0d expected %0d/%0d (closed form %0d)",
                     slot, op_phase, e.slot, e.phase, cf);
          else n_pass++;
        end
      end
  endtask

  task automatic test_mul_wrap();
    bit due, ne;
    exp_t e;
    int rev;
    longint cf;
    apply_reset();
    for (int r = 0; r < 6; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step(9'h1FF, 7, 15, 1'b0, 3'b000, 1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          rev = int'((e.edge_no - 1) / CH_CNT);
          cf = ((longint'(456832) * (rev + 1)) % 524288) >> 9;
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne || op_phase !== OUT_W'(cf))
            $display("FAIL mul_wrap: slot=%0d phase=%0d expected %0d/%0d (closed form %0d)",
                     slot, op_phase, e.slot, e.phase, cf);
          else n_pass++;
        end
      end
  endtask

  task automatic test_random();
    bit due, ne;
    exp_t e;
    bit [2:0] pv;
    for (int r = 0; r < 20; r++) begin
      pv = 3'($urandom_range(0, 7));
      for (int s = 0; s < CH_CNT; s++) begin
        step(int'($urandom_range(0, 511)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), pv, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             s == 0, due, e, ne);
        if (due) begin
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne)
            $display("FAIL random: slot=%0d phase=%0d noise=%0b expected %0d/%0d/%0b",
                     slot, op_phase, noise, e.slot, e.phase, ne);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_hold();
    bit due, ne;
    exp_t e;
    int unsigned start;
    logic [OUT_W-1:0] first [CH_CNT];
    bit seen [CH_CNT];
    for (int i = 0; i < CH_CNT; i++) seen[i] = 1'b0;
    start = m_edges + 1;
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(1'b0, r < 3, s == 0, due, e, ne);
        if (due) begin
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne)
            $display("FAIL hold: slot=%0d phase=%0d expected %0d/%0d", slot, op_phase, e.slot, e.phase);
          else n_pass++;
          if (e.edge_no >= start && e.edge_no < start + 3 * CH_CNT) begin
            if (!seen[e.slot]) begin
              seen[e.slot] = 1'b1;
              first[e.slot] = e.phase;
            end else begin
              n_total++;
              if (op_phase !== first[e.slot])
                $display("FAIL hold_repeat: slot=%0d phase=%0d expected %0d", slot, op_phase, first[e.slot]);
              else n_pass++;
            end
          end
        end
      end
  endtask

  task automatic test_sync();
    bit due, ne;
    exp_t e;
    for (int k = 0; k < 11; k++) begin
      step_def(1'b0, 1'b0, k == 0 || k == 7, due, e, ne);
      if (due) begin
        n_total++;
        if (slot !== e.slot || op_phase !== e.phase || noise !== ne)
          $display("FAIL sync: slot=%0d phase=%0d expected %0d/%0d", slot, op_phase, e.slot, e.phase);
        else n_pass++;
      end
      if (k == 10) begin
        n_total++;
        if (slot !== 6'd0)
          $display("FAIL sync_restart: slot=%0d expected 0", slot);
        else n_pass++;
      end
    end
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne)
            $display("FAIL sync_after: slot=%0d phase=%0d expected %0d/%0d", slot, op_phase, e.slot, e.phase);
          else n_pass++;
        end
      end
  endtask

  task automatic test_clock_enable();
    bit due, ne;
    exp_t e;
    logic [OUT_W-1:0] p0;
    logic [5:0] s0;
    logic n0;
    p0 = op_phase; s0 = slot; n0 = noise;
    for (int k = 0; k < 5; k++) begin
      ncen_n = 1'b1; sync = 1'b1; phase_rst = 1'b1; hold = 1'b0;
      fnum = FNUM_W'($urandom_range(0, 511)); mul = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      n_total++;
      if (op_phase !== p0 || slot !== s0 || noise !== n0)
        $display("FAIL clock_enable: phase=%0d slot=%0d noise=%0b expected %0d/%0d/%0b",
                 op_phase, slot, noise, p0, s0, n0);
      else n_pass++;
    end
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne)
            $display("FAIL enable_after: slot=%0d phase=%0d noise=%0b expected %0d/%0d/%0b",
                     slot, op_phase, noise, e.slot, e.phase, ne);
          else n_pass++;
        end
      end
  endtask

  task automatic test_reset_mid();
    bit due, ne;
    exp_t e;
    int rev;
    for (int k = 0; k < 9; k++) step_def(1'b0, 1'b0, k == 0, due, e, ne);
    apply_reset();
    n_total++;
    if (op_phase !== '0 || slot !== '0 || noise !== 1'b0)
      $display("FAIL reset_mid: phase=%0d slot=%0d noise=%0b expected 0/0/0", op_phase, slot, noise);
    else n_pass++;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < CH_CNT; s++) begin
        step_def(1'b0, 1'b0, s == 0, due, e, ne);
        if (due) begin
          rev = int'((e.edge_no - 1) / CH_CNT);
          n_total++;
          if (slot !== e.slot || op_phase !== e.phase || noise !== ne ||
              op_phase !== OUT_W'(8 * (rev + 1)))
            $display("FAIL reset_restart: slot=%0d phase=%0d noise=%0b expected %0d/%0d/%0b",
                     slot, op_phase, noise, e.slot, e.phase, ne);
          else n_pass++;
        end
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_accumulate();
    test_phase_rst();
    test_pm();
    test_mul_wrap();
    test_random();
    test_hold();
    test_sync();
    test_clock_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
